// File: rtl/cpu_dbg_pkg.sv
// Shared debug-block definitions: register-dump FSM states and default sizes.
//   DFLT_NUM_REGS / DFLT_ADDR_W / DFLT_DATA_W : CPU register file geometry
//   DFLT_HALT_TIMEOUT : cycles to wait for a halt acknowledge
package cpu_dbg_pkg;

   localparam int unsigned DFLT_NUM_REGS     = 32;
   localparam int unsigned DFLT_ADDR_W       = 5;
   localparam int unsigned DFLT_DATA_W       = 32;
   localparam int unsigned DFLT_HALT_TIMEOUT = 255;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_HALT_WAIT,
      ST_READ,
      ST_SEND,
      ST_RELEASE
   } dump_state_t;

endpackage

// File: rtl/regfile_dumper_if.sv
// Bundle between regfile_dumper and its surroundings (core halt, regfile port, dump sink).
//   master : the dumper (drives halt_req, rf_raddr, dump beat, status)
//   slave  : core / regfile / sink side
interface regfile_dumper_if
   import cpu_dbg_pkg::*;
#(
   parameter int unsigned ADDR_W = DFLT_ADDR_W,
   parameter int unsigned DATA_W = DFLT_DATA_W
);
   logic              start;
   logic              halt_req;
   logic              halt_ack;
   logic [ADDR_W-1:0] rf_raddr;
   logic [DATA_W-1:0] rf_rdata;
   logic              dump_valid;
   logic              dump_ready;
   logic [DATA_W-1:0] dump_data;
   logic [ADDR_W-1:0] dump_idx;
   logic              dump_last;
   logic              busy;
   logic              done;
   logic              error;

   modport master (
      input  start, halt_ack, rf_rdata, dump_ready,
      output halt_req, rf_raddr, dump_valid, dump_data, dump_idx, dump_last,
             busy, done, error
   );

   modport slave (
      output start, halt_ack, rf_rdata, dump_ready,
      input  halt_req, rf_raddr, dump_valid, dump_data, dump_idx, dump_last,
             busy, done, error
   );
endinterface

// File: rtl/dbg_timeout_counter.sv
// Saturating cycle counter for debug handshakes.
//   clk, rst : clock, async active-high reset
//   clear    : restart the count from zero (wins over enable)
//   enable   : count this cycle
//   expired  : registered; high while the count equals LIMIT
module dbg_timeout_counter
   import cpu_dbg_pkg::*;
#(
   parameter int unsigned LIMIT = DFLT_HALT_TIMEOUT
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   input  logic enable,
   output logic expired
);
   localparam int unsigned CNT_W = (LIMIT < 1) ? 1 : $clog2(LIMIT + 1);

   logic [CNT_W-1:0] count_q, count_d;

   // Saturate at LIMIT so expired holds until the next clear.
   always_comb begin
      count_d = count_q;
      if (clear) begin
         count_d = '0;
      end else if (enable && (count_q != CNT_W'(LIMIT))) begin
         count_d = count_q + CNT_W'(1);
      end
   end

   // expired tracks the registered count, so it is computed from count_d.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count_q <= '0;
         expired <= 1'b0;
      end else begin
         count_q <= count_d;
         expired <= (count_d == CNT_W'(LIMIT));
      end
   end
endmodule

// File: rtl/regfile_dumper.sv
// Debug reader for the CPU register file: halts the core, walks every GPR through
// one read port and streams {index, data} over valid/ready, then releases the halt.
//   clk, rst : clock, async active-high reset
//   dbg_if   : master side of regfile_dumper_if (start/halt/regfile/dump/status)
module regfile_dumper
   import cpu_dbg_pkg::*;
#(
   parameter int unsigned NUM_REGS     = DFLT_NUM_REGS,
   parameter int unsigned ADDR_W       = DFLT_ADDR_W,
   parameter int unsigned DATA_W       = DFLT_DATA_W,
   parameter int unsigned SKIP_ZERO    = 0,
   parameter int unsigned HALT_TIMEOUT = DFLT_HALT_TIMEOUT
) (
   input logic              clk,
   input logic              rst,
   regfile_dumper_if.master dbg_if
);
   localparam logic [ADDR_W-1:0] FIRST_IDX = ADDR_W'((SKIP_ZERO != 0) ? 1 : 0);
   localparam logic [ADDR_W-1:0] LAST_IDX  = ADDR_W'(NUM_REGS - 1);

   dump_state_t       state_q, state_d;
   logic [ADDR_W-1:0] idx_q, idx_d;
   logic [DATA_W-1:0] data_q, data_d;
   logic [ADDR_W-1:0] didx_q, didx_d;
   logic              last_q, last_d;
   logic              valid_q, valid_d;
   logic              halt_req_q, halt_req_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
   logic              error_q, error_d;
   logic              tmo_clear_c;
   logic              tmo_enable_c;
   logic              tmo_expired;

   assign tmo_enable_c = (state_q == ST_HALT_WAIT);

   dbg_timeout_counter #(.LIMIT(HALT_TIMEOUT)) u_halt_tmo (
      .clk     (clk),
      .rst     (rst),
      .clear   (tmo_clear_c),
      .enable  (tmo_enable_c),
      .expired (tmo_expired)
   );

   // Next-state and output-register logic.
   always_comb begin
      state_d     = state_q;
      idx_d       = idx_q;
      data_d      = data_q;
      didx_d      = didx_q;
      last_d      = last_q;
      valid_d     = valid_q;
      halt_req_d  = halt_req_q;
      error_d     = error_q;
      done_d      = 1'b0;
      tmo_clear_c = 1'b0;

      unique case (state_q)
         ST_IDLE: begin
            if (dbg_if.start) begin
               error_d     = 1'b0;
               tmo_clear_c = 1'b1;
               halt_req_d  = 1'b1;
               state_d     = ST_HALT_WAIT;
            end
         end
         ST_HALT_WAIT: begin
            // An ack arriving on the timeout cycle still wins.
            if (dbg_if.halt_ack) begin
               idx_d   = FIRST_IDX;
               state_d = ST_READ;
            end else if (tmo_expired) begin
               error_d    = 1'b1;
               halt_req_d = 1'b0;
               done_d     = 1'b1;
               state_d    = ST_RELEASE;
            end
         end
         ST_READ: begin
            // idx_q doubles as rf_raddr, so the read address has been stable all cycle.
            if (!dbg_if.halt_ack) begin
               error_d    = 1'b1;
               halt_req_d = 1'b0;
               done_d     = 1'b1;
               state_d    = ST_RELEASE;
            end else begin
               data_d  = dbg_if.rf_rdata;
               didx_d  = idx_q;
               last_d  = (idx_q == LAST_IDX);
               valid_d = 1'b1;
               state_d = ST_SEND;
            end
         end
         ST_SEND: begin
            if (dbg_if.dump_ready) begin
               valid_d = 1'b0;
               if (idx_q == LAST_IDX) begin
                  halt_req_d = 1'b0;
                  done_d     = 1'b1;
                  state_d    = ST_RELEASE;
               end else begin
                  idx_d   = idx_q + ADDR_W'(1);
                  state_d = ST_READ;
               end
            end
         end
         ST_RELEASE: begin
            if (!dbg_if.halt_ack) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      busy_d = (state_d != ST_IDLE);
   end

   // State and output registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         idx_q      <= '0;
         data_q     <= '0;
         didx_q     <= '0;
         last_q     <= 1'b0;
         valid_q    <= 1'b0;
         halt_req_q <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         error_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         idx_q      <= idx_d;
         data_q     <= data_d;
         didx_q     <= didx_d;
         last_q     <= last_d;
         valid_q    <= valid_d;
         halt_req_q <= halt_req_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         error_q    <= error_d;
      end
   end

   assign dbg_if.halt_req   = halt_req_q;
   assign dbg_if.rf_raddr   = idx_q;
   assign dbg_if.dump_valid = valid_q;
   assign dbg_if.dump_data  = data_q;
   assign dbg_if.dump_idx   = didx_q;
   assign dbg_if.dump_last  = last_q;
   assign dbg_if.busy       = busy_q;
   assign dbg_if.done       = done_q;
   assign dbg_if.error      = error_q;
endmodule

// File: tb/tb_regfile_dumper.sv
// Bench for regfile_dumper: two instances (SKIP_ZERO=0 and 1) sharing clk/rst,
// a behavioural regfile/core model and a sink with selectable backpressure.
module tb_regfile_dumper;
   import cpu_dbg_pkg::*;

   localparam int unsigned NR = 32;
   localparam int unsigned AW = 5;
   localparam int unsigned DW = 32;

   typedef struct {
      int          idx;
      logic [31:0] data;
      logic        last;
      int          cyc;
   } beat_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   int tests_run    = 0;
   int tests_failed = 0;
   int cyc          = 0;

   logic [31:0] rf [NR];

   regfile_dumper_if #(.ADDR_W(AW), .DATA_W(DW)) bus0 ();
   regfile_dumper_if #(.ADDR_W(AW), .DATA_W(DW)) bus1 ();

   regfile_dumper #(.NUM_REGS(NR), .ADDR_W(AW), .DATA_W(DW), .SKIP_ZERO(0),
                    .HALT_TIMEOUT(255)) dut0 (.clk(clk), .rst(rst), .dbg_if(bus0.master));
   regfile_dumper #(.NUM_REGS(NR), .ADDR_W(AW), .DATA_W(DW), .SKIP_ZERO(1),
                    .HALT_TIMEOUT(255)) dut1 (.clk(clk), .rst(rst), .dbg_if(bus1.master));

   // Combinational regfile read port.
   assign bus0.rf_rdata = rf[bus0.rf_raddr];
   assign bus1.rf_rdata = rf[bus1.rf_raddr];

   always @(posedge clk) cyc <= cyc + 1;

   // Monitors: beats, done cycles, halt_req cycles, hold-stability violations.
   beat_t beats0[$];
   beat_t beats1[$];
   int    done_cnt [2];
   int    hreq_cnt [2];
   int    stab_err [2];
   logic  stall0, stall1, sl0, sl1;
   logic [31:0] sd0, sd1;
   logic [4:0]  si0, si1;

   always @(negedge clk) begin
      if (rst) begin
         stall0 <= 1'b0;
      end else begin
         if (bus0.dump_valid && bus0.dump_ready)
            beats0.push_back('{int'(bus0.dump_idx), bus0.dump_data, bus0.dump_last, cyc});
         if (bus0.done)     done_cnt[0] <= done_cnt[0] + 1;
         if (bus0.halt_req) hreq_cnt[0] <= hreq_cnt[0] + 1;
         if (stall0 && (!bus0.dump_valid || bus0.dump_data !== sd0 ||
                        bus0.dump_idx !== si0 || bus0.dump_last !== sl0))
            stab_err[0] <= stab_err[0] + 1;
         stall0 <= bus0.dump_valid && !bus0.dump_ready;
         sd0 <= bus0.dump_data; si0 <= bus0.dump_idx; sl0 <= bus0.dump_last;
      end
   end

   always @(negedge clk) begin
      if (rst) begin
         stall1 <= 1'b0;
      end else begin
         if (bus1.dump_valid && bus1.dump_ready)
            beats1.push_back('{int'(bus1.dump_idx), bus1.dump_data, bus1.dump_last, cyc});
         if (bus1.done)     done_cnt[1] <= done_cnt[1] + 1;
         if (bus1.halt_req) hreq_cnt[1] <= hreq_cnt[1] + 1;
         if (stall1 && (!bus1.dump_valid || bus1.dump_data !== sd1 ||
                        bus1.dump_idx !== si1 || bus1.dump_last !== sl1))
            stab_err[1] <= stab_err[1] + 1;
         stall1 <= bus1.dump_valid && !bus1.dump_ready;
         sd1 <= bus1.dump_data; si1 <= bus1.dump_idx; sl1 <= bus1.dump_last;
      end
   end

   // Input drive / output peek by instance select.
   task automatic drive(input int sel, input logic st, input logic ack, input logic rdy);
      if (sel == 0) begin bus0.start = st; bus0.halt_ack = ack; bus0.dump_ready = rdy; end
      else          begin bus1.start = st; bus1.halt_ack = ack; bus1.dump_ready = rdy; end
   endtask

   function automatic logic f_hreq(input int sel);  return (sel == 0) ? bus0.halt_req   : bus1.halt_req;   endfunction
   function automatic logic f_busy(input int sel);  return (sel == 0) ? bus0.busy       : bus1.busy;       endfunction
   function automatic logic f_done(input int sel);  return (sel == 0) ? bus0.done       : bus1.done;       endfunction
   function automatic logic f_err(input int sel);   return (sel == 0) ? bus0.error      : bus1.error;      endfunction
   function automatic logic f_valid(input int sel); return (sel == 0) ? bus0.dump_valid : bus1.dump_valid; endfunction
   function automatic int   f_raddr(input int sel); return (sel == 0) ? int'(bus0.rf_raddr) : int'(bus1.rf_raddr); endfunction
   function automatic int   nbeats(input int sel);  return (sel == 0) ? beats0.size()   : beats1.size();   endfunction

   // Reference model: beats from index `first` up to (not incl.) `stop`, each carrying
   // rf[i], last only on index NR-1. Returns number of disagreements with the capture.
   function automatic int beat_errors(input int sel, input int base, input int first, input int stop);
      beat_t b;
      int    n;
      int    errs = 0;
      n = nbeats(sel);
      if (n - base != stop - first) errs++;
      for (int k = 0; (k < stop - first) && (base + k < n); k++) begin
         b = (sel == 0) ? beats0[base + k] : beats1[base + k];
         if (b.idx != first + k || b.data !== rf[first + k] || b.last !== ((first + k) == int'(NR - 1)))
            errs++;
      end
      return errs;
   endfunction

   // Run one dump: start, core acks after ack_delay cycles (<0: never), sink readiness
   // per rmode (0 always, 1 one-in-four, 2 random), optional ack drop in READ at drop_idx,
   // optional extra start at cycle restart_at. Ends once done was seen and busy fell.
   task automatic do_dump(input int sel, input int ack_delay, input int rmode, input int drop_idx,
                          input int restart_at, input int max_cyc, output bit to);
      logic ack = 1'b0, rdy, st;
      bit   dropped = 1'b0, seen_done = 1'b0;
      to = 1'b1;
      @(posedge clk); #1;
      drive(sel, 1'b1, 1'b0, 1'b0);
      for (int c = 1; c <= max_cyc; c++) begin
         @(posedge clk); #1;
         if (f_done(sel)) seen_done = 1'b1;
         if (seen_done && !f_busy(sel)) begin to = 1'b0; break; end
         st = (c == restart_at);
         if (!f_hreq(sel)) ack = 1'b0;
         else if (ack_delay >= 0 && c >= ack_delay && !dropped) ack = 1'b1;
         if (drop_idx >= 0 && ack && f_hreq(sel) && !f_valid(sel) && f_raddr(sel) == drop_idx) begin
            ack = 1'b0; dropped = 1'b1;
         end
         case (rmode)
            0:       rdy = 1'b1;
            1:       rdy = (c % 4 == 0);
            default: rdy = logic'($urandom_range(0, 1));
         endcase
         drive(sel, st, ack, rdy);
      end
      drive(sel, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic test_reset();
      drive(0, 1'b0, 1'b0, 1'b0);
      drive(1, 1'b0, 1'b0, 1'b0);
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      for (int s = 0; s < 2; s++) begin
         logic [47:0] v;
         v = (s == 0) ? {bus0.halt_req, bus0.rf_raddr, bus0.dump_valid, bus0.dump_data,
                         bus0.dump_idx, bus0.dump_last, bus0.busy, bus0.done, bus0.error}
                      : {bus1.halt_req, bus1.rf_raddr, bus1.dump_valid, bus1.dump_data,
                         bus1.dump_idx, bus1.dump_last, bus1.busy, bus1.done, bus1.error};
         tests_run++;
         if (v !== 48'd0) begin
            tests_failed++; $display("FAIL reset_outputs dut%0d: got %h expected 0", s, v);
         end
      end
      rst = 1'b0;
   endtask

   task automatic test_full_dump();
      int b0, d0; bit to;
      for (int i = 0; i < int'(NR); i++) rf[i] = 32'hA5A5_0000 + 32'(i);
      b0 = beats0.size(); d0 = done_cnt[0];
      do_dump(0, 3, 0, -1, -1, 400, to);
      tests_run++;
      if (to !== 1'b0) begin tests_failed++; $display("FAIL full_timeout: got %0d expected 0", to); end
      tests_run++;
      if (beat_errors(0, b0, 0, NR) !== 0) begin
         tests_failed++; $display("FAIL full_beats: got %0d bad (of %0d beats) expected 0", beat_errors(0, b0, 0, NR), beats0.size() - b0);
      end
      for (int k = b0 + 1; k < beats0.size(); k++) begin
         tests_run++;
         if (beats0[k].cyc - beats0[k-1].cyc !== 2) begin
            tests_failed++; $display("FAIL full_spacing beat %0d: got %0d cycles expected 2", k - b0, beats0[k].cyc - beats0[k-1].cyc);
         end
      end
      tests_run++;
      if (done_cnt[0] - d0 !== 1) begin tests_failed++; $display("FAIL full_done: got %0d pulses expected 1", done_cnt[0] - d0); end
      tests_run++;
      if ({bus0.error, bus0.halt_req, bus0.busy} !== 3'b000) begin
         tests_failed++; $display("FAIL full_status: got err/hreq/busy %b expected 000", {bus0.error, bus0.halt_req, bus0.busy});
      end
   endtask

   task automatic test_backpressure();
      int b0, d0, s0; bit to;
      for (int i = 0; i < int'(NR); i++) rf[i] = $urandom;
      b0 = beats0.size(); d0 = done_cnt[0]; s0 = stab_err[0];
      do_dump(0, 2, 1, -1, -1, 600, to);
      tests_run++;
      if (to !== 1'b0) begin tests_failed++; $display("FAIL bp_timeout: got %0d expected 0", to); end
      tests_run++;
      if (beat_errors(0, b0, 0, NR) !== 0) begin
         tests_failed++; $display("FAIL bp_beats: got %0d bad expected 0", beat_errors(0, b0, 0, NR));
      end
      tests_run++;
      if (stab_err[0] - s0 !== 0) begin tests_failed++; $display("FAIL bp_stable: got %0d violations expected 0", stab_err[0] - s0); end
      tests_run++;
      if (done_cnt[0] - d0 !== 1) begin tests_failed++; $display("FAIL bp_done: got %0d expected 1", done_cnt[0] - d0); end
   endtask

   task automatic test_halt_timeout();
      int b0, d0, h0; bit to;
      b0 = beats0.size(); d0 = done_cnt[0]; h0 = hreq_cnt[0];
      do_dump(0, -1, 0, -1, -1, 320, to);
      tests_run++;
      if (to !== 1'b0) begin tests_failed++; $display("FAIL tmo_ended: got timeout %0d expected 0", to); end
      tests_run++;
      if (hreq_cnt[0] - h0 !== 256) begin tests_failed++; $display("FAIL tmo_wait_cycles: got %0d expected 256", hreq_cnt[0] - h0); end
      tests_run++;
      if (beats0.size() - b0 !== 0) begin tests_failed++; $display("FAIL tmo_beats: got %0d expected 0", beats0.size() - b0); end
      tests_run++;
      if (done_cnt[0] - d0 !== 1) begin tests_failed++; $display("FAIL tmo_done: got %0d expected 1", done_cnt[0] - d0); end
      tests_run++;
      if ({bus0.error, bus0.halt_req} !== 2'b10) begin
         tests_failed++; $display("FAIL tmo_status: got err/hreq %b expected 10", {bus0.error, bus0.halt_req});
      end
   endtask

   task automatic test_skip_zero();
      int b0, d0; bit to;
      for (int i = 0; i < int'(NR); i++) rf[i] = $urandom;
      b0 = beats1.size(); d0 = done_cnt[1];
      do_dump(1, 4, 0, -1, -1, 400, to);
      tests_run++;
      if (to !== 1'b0) begin tests_failed++; $display("FAIL skip_timeout: got %0d expected 0", to); end
      tests_run++;
      if (beat_errors(1, b0, 1, NR) !== 0) begin
         tests_failed++; $display("FAIL skip_beats: got %0d bad (%0d beats) expected 0 (31 beats)", beat_errors(1, b0, 1, NR), beats1.size() - b0);
      end
      tests_run++;
      if (beats1.size() > b0 && beats1[b0].idx !== 1) begin
         tests_failed++; $display("FAIL skip_first_idx: got %0d expected 1", beats1[b0].idx);
      end
      tests_run++;
      if (done_cnt[1] - d0 !== 1 || bus1.error !== 1'b0) begin
         tests_failed++; $display("FAIL skip_done: got %0d pulses err %b expected 1 pulse err 0", done_cnt[1] - d0, bus1.error);
      end
   endtask

   task automatic test_reset_mid();
      int b0; bit hit = 1'b0, to; logic ack = 1'b0;
      for (int i = 0; i < int'(NR); i++) rf[i] = $urandom;
      @(posedge clk); #1;
      drive(0, 1'b1, 1'b0, 1'b1);
      for (int c = 1; c <= 200 && !hit; c++) begin
         @(posedge clk); #1;
         if (bus0.halt_req && c >= 2) ack = 1'b1;
         if (bus0.dump_valid && bus0.dump_idx == 5'd10) begin
            hit = 1'b1;
            drive(0, 1'b0, ack, 1'b0);
            rst = 1'b1;
            #1;
            tests_run++;
            if ({bus0.halt_req, bus0.dump_valid, bus0.busy} !== 3'b000) begin
               tests_failed++; $display("FAIL rstmid_drop: got hreq/valid/busy %b expected 000", {bus0.halt_req, bus0.dump_valid, bus0.busy});
            end
         end else begin
            drive(0, 1'b0, ack, 1'b1);
         end
      end
      tests_run++;
      if (hit !== 1'b1) begin tests_failed++; $display("FAIL rstmid_reached_idx10: got %0d expected 1", hit); end
      drive(0, 1'b0, 1'b0, 1'b0);
      @(posedge clk); @(posedge clk); #1;
      rst = 1'b0;
      b0 = beats0.size();
      do_dump(0, 3, 0, -1, -1, 400, to);
      tests_run++;
      if (to !== 1'b0 || beat_errors(0, b0, 0, NR) !== 0) begin
         tests_failed++; $display("FAIL rstmid_fresh_dump: got timeout %0d bad %0d expected 0 0", to, beat_errors(0, b0, 0, NR));
      end
   endtask

   task automatic test_start_busy_abort();
      int b0, d0, h0; bit to;
      for (int i = 0; i < int'(NR); i++) rf[i] = $urandom;
      b0 = beats0.size(); d0 = done_cnt[0];
      do_dump(0, 3, 0, 5, 8, 400, to);
      tests_run++;
      if (to !== 1'b0) begin tests_failed++; $display("FAIL abort_timeout: got %0d expected 0", to); end
      tests_run++;
      if (beat_errors(0, b0, 0, 5) !== 0) begin
         tests_failed++; $display("FAIL abort_beats: got %0d bad (%0d beats) expected 0 (5 beats)", beat_errors(0, b0, 0, 5), beats0.size() - b0);
      end
      tests_run++;
      if (done_cnt[0] - d0 !== 1 || bus0.error !== 1'b1) begin
         tests_failed++; $display("FAIL abort_done_err: got %0d pulses err %b expected 1 pulse err 1", done_cnt[0] - d0, bus0.error);
      end
      h0 = hreq_cnt[0];
      repeat (10) @(posedge clk);
      #1;
      tests_run++;
      if (hreq_cnt[0] - h0 !== 0 || bus0.busy !== 1'b0) begin
         tests_failed++; $display("FAIL abort_no_restart: got hreq cycles %0d busy %b expected 0 0", hreq_cnt[0] - h0, bus0.busy);
      end
   endtask

   task automatic test_random();
      int b0, d0, s0, sel, first; bit to;
      for (int it = 0; it < 4; it++) begin
         sel   = it % 2;
         first = sel;
         for (int i = 0; i < int'(NR); i++) rf[i] = $urandom;
         b0 = nbeats(sel); d0 = done_cnt[sel]; s0 = stab_err[sel];
         do_dump(sel, int'($urandom_range(1, 20)), 2, -1, -1, 1500, to);
         tests_run++;
         if (to !== 1'b0 || beat_errors(sel, b0, first, NR) !== 0) begin
            tests_failed++; $display("FAIL rand%0d_beats: got timeout %0d bad %0d expected 0 0", it, to, beat_errors(sel, b0, first, NR));
         end
         tests_run++;
         if (done_cnt[sel] - d0 !== 1 || stab_err[sel] - s0 !== 0 || f_err(sel) !== 1'b0) begin
            tests_failed++; $display("FAIL rand%0d_status: got done %0d stab %0d err %b expected 1 0 0", it, done_cnt[sel] - d0, stab_err[sel] - s0, f_err(sel));
         end
      end
   endtask

   initial begin
      test_reset();
      test_full_dump();
      test_backpressure();
      test_halt_timeout();
      test_skip_zero();
      test_reset_mid();
      test_start_busy_abort();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end
endmodule
